// File: rtl/insn_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem read, one-entry instruction register to decode.
// Ack in N -> insn_valid in N+1; transfer in N -> next imem_req in N+1; redirects drop stale fetches.
module insn_fetch_unit #(
   parameter int          PC_WIDTH   = 12,
   parameter int          INSN_WIDTH = 32,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic                  imem_ack,
   input  logic [INSN_WIDTH-1:0] imem_rdata,
   input  logic                  redirect,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   output logic                  insn_valid,
   input  logic                  insn_ready,
   output logic [INSN_WIDTH-1:0] insn,
   output logic [PC_WIDTH-1:0]   insn_pc,
   output logic [4:0]            opcode
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [PC_WIDTH-1:0]   r_tgt;
   logic                  r_kill;
   logic                  r_req;
   logic                  r_valid;
   logic [INSN_WIDTH-1:0] r_insn;
   logic [PC_WIDTH-1:0]   r_insn_pc;
   logic [PC_WIDTH-1:0]   w_pc_inc;

   assign w_pc_inc   = r_pc + PC_WIDTH'(1);
   assign imem_req   = r_req;
   assign imem_addr  = r_pc;
   assign insn_valid = r_valid;
   assign insn       = r_insn;
   assign insn_pc    = r_insn_pc;
   assign opcode     = r_insn[INSN_WIDTH-1 -: 5];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= BOOT;
         r_pc      <= PC_WIDTH'(RESET_PC);
         r_tgt     <= '0;
         r_kill    <= 1'b0;
         r_req     <= 1'b0;
         r_valid   <= 1'b0;
         r_insn    <= '0;
         r_insn_pc <= '0;
      end else begin
         case (r_state)
            BOOT: begin
               if (redirect) r_pc <= redirect_pc;
               r_req   <= 1'b1;
               r_state <= REQ;
            end
            REQ: begin
               // The address must stay put until the memory answers, so a redirect
               // that arrives early is parked in r_tgt and the late word is discarded.
               if (imem_ack) begin
                  if (r_kill || redirect) begin
                     r_pc   <= redirect ? redirect_pc : r_tgt;
                     r_kill <= 1'b0;
                  end else begin
                     r_insn    <= imem_rdata;
                     r_insn_pc <= r_pc;
                     r_pc      <= w_pc_inc;
                     r_valid   <= 1'b1;
                     r_req     <= 1'b0;
                     r_state   <= HOLD;
                  end
               end else if (redirect) begin
                  r_kill <= 1'b1;
                  r_tgt  <= redirect_pc;
               end
            end
            HOLD: begin
               if (redirect) begin
                  r_valid <= 1'b0;
                  r_pc    <= redirect_pc;
                  r_req   <= 1'b1;
                  r_state <= REQ;
               end else if (insn_ready) begin
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_state <= REQ;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_valid <= 1'b0;
               r_state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Bench for insn_fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_insn_fetch_unit;
   localparam int PW = 12;
   localparam int IW = 32;

   logic          clock;
   logic          reset_n;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_rdata;
   logic          redirect;
   logic [PW-1:0] redirect_pc;
   logic          insn_valid;
   logic          insn_ready;
   logic [IW-1:0] insn;
   logic [PW-1:0] insn_pc;
   logic [4:0]    opcode;

   logic [IW-1:0] mem [0:(1<<PW)-1];
   int n_cmp;
   int n_fail;

   insn_fetch_unit #(.PC_WIDTH(PW), .INSN_WIDTH(IW), .RESET_PC(0)) dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc), .opcode(opcode)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change on the falling edge; outputs are observed there too.
   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic reset_dut();
      imem_ack = 1'b0; redirect = 1'b0; insn_ready = 1'b0; redirect_pc = '0; imem_rdata = '0;
      reset_n = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      logic [IW-1:0] w0;
      reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = mem[0]; redirect = 1'b0; insn_ready = 1'b1; redirect_pc = '0;
      @(negedge clock);
      cyc();
      n_cmp++;
      if ({imem_req, insn_valid, insn, insn_pc, opcode} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b valid=%b insn=%h pc=%h op=%h, required all zero",
                  imem_req, insn_valid, insn, insn_pc, opcode);
      end
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: imem_req=%b required 0", imem_req); end
      @(negedge clock);
      w0 = '0;
      n_cmp++;
      if ({imem_req, imem_addr, insn_valid, insn} !== {1'b1, 12'h000, 1'b0, w0}) begin
         n_fail++;
         $display("FAIL boot_ack_ignored: req=%b addr=%h valid=%b insn=%h, required req=1 addr=000 valid=0 insn=0",
                  imem_req, imem_addr, insn_valid, insn);
      end
   endtask

   task automatic test_sequential();
      logic [PW-1:0] exp_pc;
      logic acked;
      int n;
      int budget;
      reset_dut();
      exp_pc = '0; n = 0; budget = 0;
      while (n < 4 && budget < 40) begin
         imem_ack = imem_req; imem_rdata = mem[imem_addr]; insn_ready = 1'b1; redirect = 1'b0;
         acked = imem_req;
         cyc(); budget++;
         if (acked) begin
            n_cmp++;
            if (insn_valid !== 1'b1) begin n_fail++; $display("FAIL seq_latency: insn_valid=%b required 1", insn_valid); end
         end
         if (insn_valid) begin
            n_cmp++;
            if ({insn_pc, insn, opcode} !== {exp_pc, mem[exp_pc], mem[exp_pc][31:27]}) begin
               n_fail++;
               $display("FAIL seq_insn: pc=%h insn=%h op=%h, required pc=%h insn=%h op=%h",
                        insn_pc, insn, opcode, exp_pc, mem[exp_pc], mem[exp_pc][31:27]);
            end
            exp_pc++; n++;
         end
      end
      n_cmp++;
      if (n != 4) begin n_fail++; $display("FAIL seq_timeout: presented %0d required 4", n); end
   endtask

   task automatic test_hold_stall();
      reset_dut();
      imem_ack = 1'b1; imem_rdata = mem[0]; insn_ready = 1'b0;
      cyc();
      imem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_cmp++;
         if ({insn_valid, imem_req, insn, insn_pc} !== {1'b1, 1'b0, mem[0], 12'h000}) begin
            n_fail++;
            $display("FAIL hold_stall[%0d]: valid=%b req=%b insn=%h pc=%h, required 1 0 %h 000",
                     i, insn_valid, imem_req, insn, insn_pc, mem[0]);
         end
      end
      insn_ready = 1'b1;
      cyc();
      n_cmp++;
      if ({insn_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 12'h001}) begin
         n_fail++;
         $display("FAIL hold_release: valid=%b req=%b addr=%h, required 0 1 001", insn_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_wait();
      reset_dut();
      redirect = 1'b1; redirect_pc = 12'h005;
      cyc();
      redirect = 1'b0; imem_ack = 1'b1; imem_rdata = mem[0];
      cyc();
      n_cmp++;
      if ({imem_req, imem_addr, insn_valid} !== {1'b1, 12'h005, 1'b0}) begin
         n_fail++;
         $display("FAIL rw_setup: req=%b addr=%h valid=%b, required 1 005 0", imem_req, imem_addr, insn_valid);
      end
      imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 12'h040;
      for (int i = 0; i < 3; i++) begin
         cyc();
         redirect = 1'b0;
         n_cmp++;
         if ({imem_req, imem_addr, insn_valid} !== {1'b1, 12'h005, 1'b0}) begin
            n_fail++;
            $display("FAIL rw_addr_hold[%0d]: req=%b addr=%h valid=%b, required 1 005 0", i, imem_req, imem_addr, insn_valid);
         end
      end
      imem_ack = 1'b1; imem_rdata = mem[5];
      cyc();
      n_cmp++;
      if ({imem_req, imem_addr, insn_valid} !== {1'b1, 12'h040, 1'b0}) begin
         n_fail++;
         $display("FAIL rw_stale_dropped: req=%b addr=%h valid=%b, required 1 040 0", imem_req, imem_addr, insn_valid);
      end
      imem_rdata = mem[12'h040];
      cyc();
      imem_ack = 1'b0;
      n_cmp++;
      if ({insn_valid, insn_pc, insn} !== {1'b1, 12'h040, mem[12'h040]}) begin
         n_fail++;
         $display("FAIL rw_target_insn: valid=%b pc=%h insn=%h, required 1 040 %h", insn_valid, insn_pc, insn, mem[12'h040]);
      end
   endtask

   task automatic test_redirect_ack();
      reset_dut();
      imem_ack = 1'b1; imem_rdata = mem[0]; redirect = 1'b1; redirect_pc = 12'h100;
      cyc();
      redirect = 1'b0;
      n_cmp++;
      if ({imem_req, imem_addr, insn_valid} !== {1'b1, 12'h100, 1'b0}) begin
         n_fail++;
         $display("FAIL ra_drop: req=%b addr=%h valid=%b, required 1 100 0", imem_req, imem_addr, insn_valid);
      end
      imem_rdata = mem[12'h100];
      cyc();
      imem_ack = 1'b0;
      n_cmp++;
      if ({insn_valid, insn_pc, insn} !== {1'b1, 12'h100, mem[12'h100]}) begin
         n_fail++;
         $display("FAIL ra_target_insn: valid=%b pc=%h insn=%h, required 1 100 %h", insn_valid, insn_pc, insn, mem[12'h100]);
      end
   endtask

   task automatic test_hold_redirect();
      reset_dut();
      imem_ack = 1'b1; imem_rdata = mem[0]; insn_ready = 1'b0;
      cyc();
      imem_ack = 1'b0; insn_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'h2A0;
      cyc();
      redirect = 1'b0; insn_ready = 1'b0;
      n_cmp++;
      if ({insn_valid, imem_req, imem_addr, insn, insn_pc} !== {1'b0, 1'b1, 12'h2A0, mem[0], 12'h000}) begin
         n_fail++;
         $display("FAIL hr_release: valid=%b req=%b addr=%h insn=%h pc=%h, required 0 1 2a0 %h 000",
                  insn_valid, imem_req, imem_addr, insn, insn_pc, mem[0]);
      end
      imem_ack = 1'b1; imem_rdata = mem[12'h2A0];
      cyc();
      imem_ack = 1'b0;
      n_cmp++;
      if ({insn_valid, insn_pc, insn} !== {1'b1, 12'h2A0, mem[12'h2A0]}) begin
         n_fail++;
         $display("FAIL hr_next_insn: valid=%b pc=%h insn=%h, required 1 2a0 %h", insn_valid, insn_pc, insn, mem[12'h2A0]);
      end
   endtask

   task automatic test_wrap_and_reset();
      reset_dut();
      imem_ack = 1'b1; imem_rdata = mem[0]; redirect = 1'b1; redirect_pc = 12'hFFF;
      cyc();
      redirect = 1'b0; imem_rdata = mem[12'hFFF]; insn_ready = 1'b1;
      cyc();
      imem_ack = 1'b0;
      n_cmp++;
      if ({insn_valid, insn_pc, insn} !== {1'b1, 12'hFFF, mem[12'hFFF]}) begin
         n_fail++;
         $display("FAIL wrap_insn: valid=%b pc=%h insn=%h, required 1 fff %h", insn_valid, insn_pc, insn, mem[12'hFFF]);
      end
      cyc();
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 12'h000}) begin
         n_fail++;
         $display("FAIL wrap_addr: req=%b addr=%h, required 1 000", imem_req, imem_addr);
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({imem_req, insn_valid, insn, insn_pc} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: req=%b valid=%b insn=%h pc=%h, required all zero", imem_req, insn_valid, insn, insn_pc);
      end
      @(negedge clock);
      reset_n = 1'b1; redirect = 1'b1; redirect_pc = 12'h777;
      cyc();
      redirect = 1'b0;
      n_cmp++;
      if ({imem_req, imem_addr, insn_valid} !== {1'b1, 12'h777, 1'b0}) begin
         n_fail++;
         $display("FAIL boot_redirect: req=%b addr=%h valid=%b, required 1 777 0", imem_req, imem_addr, insn_valid);
      end
      reset_dut();
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 12'h000}) begin
         n_fail++;
         $display("FAIL refetch_reset_pc: req=%b addr=%h, required 1 000", imem_req, imem_addr);
      end
   endtask

   // Model: the next word decode should see is exp_next; a redirect retargets it, and an
   // ack for any other address is a stale fetch that must never surface.
   task automatic test_random();
      logic [PW-1:0] exp_next, e_addr, h_pc, rpc;
      logic [IW-1:0] h_insn;
      logic e_fresh, e_drop, e_rel, e_wait, e_stall, r;
      int gap, max_gap, presented;
      reset_dut();
      exp_next = '0; e_addr = '0; h_pc = '0; h_insn = '0;
      e_fresh = 1'b0; e_drop = 1'b0; e_rel = 1'b0; e_wait = 1'b0; e_stall = 1'b0;
      gap = 0; max_gap = 0; presented = 0;
      for (int c = 0; c < 3000; c++) begin
         n_cmp++;
         if (imem_req && insn_valid) begin n_fail++; $display("FAIL rnd_exclusive[%0d]: req=1 valid=1, required not both", c); end
         if (e_fresh) begin
            n_cmp++; presented++;
            if ({insn_valid, insn_pc, insn, opcode} !== {1'b1, e_addr, mem[e_addr], mem[e_addr][31:27]}) begin
               n_fail++;
               $display("FAIL rnd_fresh[%0d]: valid=%b pc=%h insn=%h op=%h, required 1 %h %h %h",
                        c, insn_valid, insn_pc, insn, opcode, e_addr, mem[e_addr], mem[e_addr][31:27]);
            end
         end
         if (e_drop || e_rel) begin
            n_cmp++;
            if ({insn_valid, imem_req, imem_addr} !== {1'b0, 1'b1, exp_next}) begin
               n_fail++;
               $display("FAIL rnd_next_req[%0d]: valid=%b req=%b addr=%h, required 0 1 %h", c, insn_valid, imem_req, imem_addr, exp_next);
            end
         end
         if (e_wait) begin
            n_cmp++;
            if ({insn_valid, imem_req, imem_addr} !== {1'b0, 1'b1, e_addr}) begin
               n_fail++;
               $display("FAIL rnd_wait[%0d]: valid=%b req=%b addr=%h, required 0 1 %h", c, insn_valid, imem_req, imem_addr, e_addr);
            end
         end
         if (e_stall) begin
            n_cmp++;
            if ({insn_valid, imem_req, insn, insn_pc} !== {1'b1, 1'b0, h_insn, h_pc}) begin
               n_fail++;
               $display("FAIL rnd_stall[%0d]: valid=%b req=%b insn=%h pc=%h, required 1 0 %h %h",
                        c, insn_valid, imem_req, insn, insn_pc, h_insn, h_pc);
            end
         end
         gap = insn_valid ? 0 : gap + 1;
         if (gap > max_gap) max_gap = gap;

         r   = ($urandom_range(0, 9) == 0);
         rpc = PW'($urandom_range(0, 4095));
         if ($urandom_range(0, 7) == 0) rpc = 12'hFFF;
         if (imem_req && rpc == imem_addr) rpc = rpc + 1'b1;
         imem_ack    = imem_req && ($urandom_range(0, 2) != 0);
         imem_rdata  = mem[imem_addr];
         insn_ready  = ($urandom_range(0, 3) != 0);
         redirect    = r;
         redirect_pc = rpc;

         e_fresh = imem_ack && !r && (imem_addr == exp_next);
         e_drop  = imem_ack && !e_fresh;
         e_wait  = imem_req && !imem_ack;
         e_rel   = insn_valid && (insn_ready || r);
         e_stall = insn_valid && !insn_ready && !r;
         e_addr  = imem_addr; h_insn = insn; h_pc = insn_pc;
         if (r) exp_next = rpc;
         else if (e_fresh) exp_next = imem_addr + 1'b1;
         cyc();
      end
      imem_ack = 1'b0; redirect = 1'b0;
      n_cmp++;
      if (max_gap > 60 || presented < 100) begin
         n_fail++;
         $display("FAIL rnd_progress: max_gap=%0d presented=%0d, required gap<=60 presented>=100", max_gap, presented);
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; insn_ready = 1'b0;
      for (int i = 0; i < (1 << PW); i++) mem[i] = $urandom();
      test_reset();
      test_sequential();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_ack();
      test_hold_redirect();
      test_wrap_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
